// File: rtl/bm_access_arbiter.sv
// Shares the block-map memory port between the stage loader, per-ball clears and the drop effect.
// Define BM_ARB_RR_EN for round-robin arbitration among clears (fixed lowest-index priority otherwise).
module bm_access_arbiter #(
   parameter int BALL_NUM = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_req,
   input  logic [1:0]            load_stage,
   input  logic [BALL_NUM-1:0]   clr_req,
   input  logic [BALL_NUM*5-1:0] clr_row,
   input  logic [BALL_NUM*5-1:0] clr_col,
   input  logic                  drop_req,
   input  logic [4:0]            scan_row,
   input  logic [4:0]            scan_col,
   input  logic                  bm_ready,
   output logic                  bm_enable,
   output logic [1:0]            bm_func,
   output logic [4:0]            bm_row,
   output logic [4:0]            bm_col,
   output logic [1:0]            bm_stage,
   output logic                  load_ack,
   output logic                  drop_ack,
   output logic [BALL_NUM-1:0]   clr_ack,
   output logic                  busy
);

   localparam logic [1:0] F_NONE  = 2'b00;
   localparam logic [1:0] F_LOAD  = 2'b01;
   localparam logic [1:0] F_CLEAR = 2'b10;
   localparam logic [1:0] F_DROP  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t                    state_q, state_d;
   logic                      wait_first_q, wait_first_d;
   logic                      load_pend_q, load_pend_d;
   logic [1:0]                stage_pend_q, stage_pend_d;
   logic                      drop_pend_q, drop_pend_d;
   logic [BALL_NUM-1:0]       clr_pend_q, clr_pend_d;
   logic [BALL_NUM-1:0][4:0]  clr_row_q, clr_row_d;
   logic [BALL_NUM-1:0][4:0]  clr_col_q, clr_col_d;
   logic                      bm_enable_q, bm_enable_d;
   logic [1:0]                bm_func_q, bm_func_d;
   logic [4:0]                cmd_row_q, cmd_row_d;
   logic [4:0]                cmd_col_q, cmd_col_d;
   logic [1:0]                bm_stage_q, bm_stage_d;
   logic                      load_ack_q, load_ack_d;
   logic                      drop_ack_q, drop_ack_d;
   logic [BALL_NUM-1:0]       clr_ack_q, clr_ack_d;
   logic [BALL_NUM-1:0]       clr_keep;
   logic                      clr_found;
   int                        win_idx;

`ifdef BM_ARB_RR_EN
   localparam int PW = (BALL_NUM > 1) ? $clog2(BALL_NUM) : 1;
   logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
`endif

   // A slot being acked this cycle drops out unless a fresh request re-arms it.
   assign clr_keep = clr_pend_q & ~clr_ack_q;

   always_comb begin
      state_d      = state_q;
      wait_first_d = wait_first_q;
      stage_pend_d = stage_pend_q;
      clr_row_d    = clr_row_q;
      clr_col_d    = clr_col_q;
      cmd_row_d    = cmd_row_q;
      cmd_col_d    = cmd_col_q;
      bm_stage_d   = bm_stage_q;
      bm_enable_d  = 1'b0;
      bm_func_d    = F_NONE;
      load_ack_d   = 1'b0;
      drop_ack_d   = 1'b0;
      clr_ack_d    = '0;
      clr_found    = 1'b0;
      win_idx      = 0;
`ifdef BM_ARB_RR_EN
      rr_ptr_d     = rr_ptr_q;
`endif

      load_pend_d = (load_pend_q & ~load_ack_q) | load_req;
      if (load_req) begin
         stage_pend_d = load_stage;
      end
      drop_pend_d = ~load_req & ((drop_pend_q & ~drop_ack_q) | drop_req);
      for (int i = 0; i < BALL_NUM; i++) begin
         clr_pend_d[i] = ~load_req & (clr_keep[i] | clr_req[i]);
         if (clr_req[i] && !clr_keep[i]) begin
            clr_row_d[i] = clr_row[i*5 +: 5];
            clr_col_d[i] = clr_col[i*5 +: 5];
         end
      end

`ifdef BM_ARB_RR_EN
      for (int j = 0; j < BALL_NUM; j++) begin
         if (!clr_found && clr_pend_d[(int'(rr_ptr_q) + j) % BALL_NUM]) begin
            clr_found = 1'b1;
            win_idx   = (int'(rr_ptr_q) + j) % BALL_NUM;
         end
      end
`else
      for (int j = BALL_NUM - 1; j >= 0; j--) begin
         if (clr_pend_d[j]) begin
            clr_found = 1'b1;
            win_idx   = j;
         end
      end
`endif

      // Arbitration sees this cycle's requests so an uncontested pulse issues on the next cycle.
      case (state_q)
         S_IDLE: begin
            if (bm_ready && (load_pend_d || clr_found || drop_pend_d)) begin
               state_d     = S_ISSUE;
               bm_enable_d = 1'b1;
               if (load_pend_d) begin
                  bm_func_d  = F_LOAD;
                  load_ack_d = 1'b1;
                  bm_stage_d = stage_pend_d;
                  cmd_row_d  = 5'd0;
                  cmd_col_d  = 5'd0;
               end else if (clr_found) begin
                  bm_func_d          = F_CLEAR;
                  clr_ack_d[win_idx] = 1'b1;
                  cmd_row_d          = clr_row_d[win_idx];
                  cmd_col_d          = clr_col_d[win_idx];
`ifdef BM_ARB_RR_EN
                  rr_ptr_d           = PW'((win_idx + 1) % BALL_NUM);
`endif
               end else begin
                  bm_func_d  = F_DROP;
                  drop_ack_d = 1'b1;
                  cmd_row_d  = 5'd0;
                  cmd_col_d  = 5'd0;
               end
            end
         end
         S_ISSUE: begin
            state_d      = S_WAIT;
            wait_first_d = 1'b1;
         end
         S_WAIT: begin
            wait_first_d = 1'b0;
            if (!wait_first_q && bm_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wait_first_q <= 1'b0;
         load_pend_q  <= 1'b0;
         stage_pend_q <= 2'd0;
         drop_pend_q  <= 1'b0;
         clr_pend_q   <= '0;
         clr_row_q    <= '0;
         clr_col_q    <= '0;
         bm_enable_q  <= 1'b0;
         bm_func_q    <= F_NONE;
         cmd_row_q    <= 5'd0;
         cmd_col_q    <= 5'd0;
         bm_stage_q   <= 2'd0;
         load_ack_q   <= 1'b0;
         drop_ack_q   <= 1'b0;
         clr_ack_q    <= '0;
`ifdef BM_ARB_RR_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wait_first_q <= wait_first_d;
         load_pend_q  <= load_pend_d;
         stage_pend_q <= stage_pend_d;
         drop_pend_q  <= drop_pend_d;
         clr_pend_q   <= clr_pend_d;
         clr_row_q    <= clr_row_d;
         clr_col_q    <= clr_col_d;
         bm_enable_q  <= bm_enable_d;
         bm_func_q    <= bm_func_d;
         cmd_row_q    <= cmd_row_d;
         cmd_col_q    <= cmd_col_d;
         bm_stage_q   <= bm_stage_d;
         load_ack_q   <= load_ack_d;
         drop_ack_q   <= drop_ack_d;
         clr_ack_q    <= clr_ack_d;
`ifdef BM_ARB_RR_EN
         rr_ptr_q     <= rr_ptr_d;
`endif
      end
   end

   assign bm_enable = bm_enable_q;
   assign bm_func   = bm_func_q;
   assign bm_stage  = bm_stage_q;
   assign load_ack  = load_ack_q;
   assign drop_ack  = drop_ack_q;
   assign clr_ack   = clr_ack_q;
   assign bm_row    = (state_q == S_ISSUE) ? cmd_row_q : scan_row;
   assign bm_col    = (state_q == S_ISSUE) ? cmd_col_q : scan_col;
   assign busy      = (state_q != S_IDLE) | load_pend_q | drop_pend_q | (|clr_pend_q);

endmodule
